// File: rtl/data_lane_cal_if.sv
// Command/data bundle for data_lane_cal: packed-lane source, command handshake and result stream.
// The master side is the requester, the slave side is the lane calculator.
interface data_lane_cal_if #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
);
    localparam int SEL_W = $clog2(LANES);
    localparam int OUT_W = LANE_W + $clog2(LANES);

    logic                    load;
    logic [LANE_W*LANES-1:0] d;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd_op;
    logic [SEL_W-1:0]        cmd_sel;
    logic [OUT_W-1:0]        out;
    logic                    validout;
    logic                    last;
    logic                    busy;

    modport master (
        output load, d, cmd_valid, cmd_op, cmd_sel,
        input  cmd_ready, out, validout, last, busy
    );

    modport slave (
        input  load, d, cmd_valid, cmd_op, cmd_sel,
        output cmd_ready, out, validout, last, busy
    );
endinterface

// File: rtl/data_lane_cal.sv
// Lane calculator: holds a packed word of LANES lanes and produces lane0+/-lane[sel],
// a lane0+lane[k] scan, or the sum of all lanes on a valid/ready command.
module data_lane_cal #(
    parameter  int LANE_W = 4,
    parameter  int LANES  = 4,
    localparam int SEL_W  = $clog2(LANES),
    localparam int OUT_W  = LANE_W + $clog2(LANES)
) (
    input logic           clk,
    input logic           rst,
    data_lane_cal_if.slave bus
);
    localparam int CNT_W = $clog2(LANES + 1);

    // ADD/ABSDIFF finish on the accept edge, so only the multi-cycle ops hold a state.
    typedef enum logic [1:0] {IDLE, SCAN, SUMALL} state_t;

    state_t                       state, state_nxt;
    logic [LANES-1:0][LANE_W-1:0] hold, hold_nxt, opnd;
    logic [OUT_W-1:0]             acc, acc_nxt, acc_sum;
    logic [OUT_W-1:0]             out_q, out_nxt;
    logic [CNT_W-1:0]             k, k_nxt;
    logic                         vld_q, vld_nxt;
    logic                         last_q, last_nxt;
    logic                         accept;
    logic [LANE_W-1:0]            sel_lane;
    logic [LANE_W-1:0]            k_lane;

    function automatic logic [OUT_W-1:0] zx(input logic [LANE_W-1:0] v);
        return OUT_W'(v);
    endfunction

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out       = out_q;
    assign bus.validout  = vld_q;
    assign bus.last      = last_q;

    assign accept = bus.cmd_valid && bus.cmd_ready;
    // A load on the accept edge bypasses the holding register.
    assign opnd   = (state == IDLE && bus.load) ? bus.d : hold;
    assign k_lane = hold[k[SEL_W-1:0]];
    assign acc_sum = acc + zx(k_lane);

    // Out-of-range selects fall back to lane 0.
    always_comb begin
        sel_lane = opnd[0];
        if (32'(bus.cmd_sel) < LANES)
            sel_lane = opnd[bus.cmd_sel];
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        acc_nxt   = acc;
        k_nxt     = k;
        out_nxt   = out_q;
        vld_nxt   = 1'b0;
        last_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load)
                    hold_nxt = bus.d;
                if (accept) begin
                    case (bus.cmd_op)
                        2'd0: begin
                            out_nxt  = zx(opnd[0]) + zx(sel_lane);
                            vld_nxt  = 1'b1;
                            last_nxt = 1'b1;
                        end
                        2'd1: begin
                            out_nxt  = (opnd[0] >= sel_lane) ? zx(opnd[0] - sel_lane)
                                                             : zx(sel_lane - opnd[0]);
                            vld_nxt  = 1'b1;
                            last_nxt = 1'b1;
                        end
                        2'd2: begin
                            out_nxt   = zx(opnd[0]) + zx(opnd[1]);
                            vld_nxt   = 1'b1;
                            last_nxt  = (LANES == 2);
                            k_nxt     = CNT_W'(2);
                            state_nxt = SCAN;
                        end
                        default: begin
                            acc_nxt   = zx(opnd[0]);
                            k_nxt     = CNT_W'(1);
                            state_nxt = SUMALL;
                        end
                    endcase
                end
            end
            SCAN: begin
                // k runs one past the last lane so busy covers the final result cycle.
                if (k == CNT_W'(LANES)) begin
                    state_nxt = IDLE;
                end else begin
                    out_nxt  = zx(hold[0]) + zx(k_lane);
                    vld_nxt  = 1'b1;
                    last_nxt = (k == CNT_W'(LANES - 1));
                    k_nxt    = k + CNT_W'(1);
                end
            end
            SUMALL: begin
                if (k == CNT_W'(LANES - 1)) begin
                    out_nxt   = acc_sum;
                    vld_nxt   = 1'b1;
                    last_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    acc_nxt = acc_sum;
                    k_nxt   = k + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            hold   <= '0;
            acc    <= '0;
            k      <= '0;
            out_q  <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            hold   <= hold_nxt;
            acc    <= acc_nxt;
            k      <= k_nxt;
            out_q  <= out_nxt;
            vld_q  <= vld_nxt;
            last_q <= last_nxt;
        end
    end
endmodule

// File: tb/tb_data_lane_cal.sv
// Bench for data_lane_cal: directed literal cases, then randomized commands checked
// every cycle against a cycle-indexed reference model of the results.
module tb_data_lane_cal;
    localparam int LANE_W = 4;
    localparam int LANES  = 4;
    localparam int DW     = LANE_W * LANES;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   en = 1'b0;

    // Reference model state
    int             exp_out[int];
    bit             exp_last[int];
    int             bs = 0, be = 0;
    int             hold_out = 0;
    logic [DW-1:0]  mhold = '0;

    data_lane_cal_if #(.LANE_W(LANE_W), .LANES(LANES)) bus();

    data_lane_cal #(.LANE_W(LANE_W), .LANES(LANES)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ref_result(input int op, input int sel, input logic [DW-1:0] w, input int k);
        int ln[LANES];
        int s;
        for (int i = 0; i < LANES; i++) ln[i] = int'((w >> (i * LANE_W)) & ((1 << LANE_W) - 1));
        if (sel >= LANES) sel = 0;
        case (op)
            0: return ln[0] + ln[sel];
            1: return (ln[0] > ln[sel]) ? ln[0] - ln[sel] : ln[sel] - ln[0];
            2: return ln[0] + ln[k];
            default: begin
                s = 0;
                for (int i = 0; i < LANES; i++) s += ln[i];
                return s;
            end
        endcase
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (en) begin
            automatic int c = cyc;
            automatic bit bz = (c >= bs && c < be);
            chk("rnd_busy", bus.busy, bz);
            chk("rnd_ready", bus.cmd_ready, !bz);
            if (exp_out.exists(c)) begin
                chk("rnd_valid", bus.validout, 1);
                chk("rnd_out", bus.out, exp_out[c]);
                chk("rnd_last", bus.last, exp_last[c]);
                hold_out = exp_out[c];
                exp_out.delete(c);
                exp_last.delete(c);
            end else begin
                chk("rnd_novalid", bus.validout, 0);
                chk("rnd_nolast", bus.last, 0);
                chk("rnd_hold", bus.out, hold_out);
            end
        end
    end

    task automatic issue(input int op, input int sel, input bit ld, input logic [DW-1:0] dv);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'(op);
        bus.cmd_sel   = 2'(sel);
        bus.load      = ld;
        bus.d         = dv;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.load      = 1'b0;
    endtask

    task automatic res(input string nm, input int o, input int v, input int l);
        chk({nm, "_out"}, bus.out, o);
        chk({nm, "_valid"}, bus.validout, v);
        chk({nm, "_last"}, bus.last, l);
    endtask

    initial begin
        bit p_valid = 0;
        int p_op = 0, p_sel = 0, e, n;
        bit ld, idle;
        logic [DW-1:0] dv;

        bus.load = 0; bus.d = '0; bus.cmd_valid = 0; bus.cmd_op = '0; bus.cmd_sel = '0;

        chk("model_add", ref_result(0, 3, 16'hF3A5, 0), 20);
        chk("model_scan", ref_result(2, 0, 16'hF3A5, 2), 8);
        chk("model_sum", ref_result(3, 0, 16'hF3A5, 0), 33);

        repeat (2) @(posedge clk); #1;
        @(negedge clk);
        res("reset", 0, 0, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_ready", bus.cmd_ready, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        bus.load = 1; bus.d = 16'hF3A5;
        @(posedge clk); #1;
        bus.load = 0;

        issue(0, 1, 0, '0); @(negedge clk); res("add1", 15, 1, 1);
        chk("add1_ready", bus.cmd_ready, 1);
        issue(0, 3, 0, '0); @(negedge clk); res("add3", 20, 1, 1);
        issue(1, 2, 0, '0); @(negedge clk); res("abs2", 2, 1, 1);
        issue(1, 0, 0, '0); @(negedge clk); res("abs0", 0, 1, 1);
        issue(0, 0, 0, '0); @(negedge clk); res("add0", 10, 1, 1);
        @(negedge clk); res("idle_hold", 10, 0, 0);

        // SCAN with a load attempted while busy
        issue(2, 0, 0, '0);
        bus.load = 1; bus.d = 16'h1111;
        @(negedge clk); res("scan1", 15, 1, 0); chk("scan1_busy", bus.busy, 1);
        @(posedge clk); #1; bus.load = 0;
        @(negedge clk); res("scan2", 8, 1, 0); chk("scan2_busy", bus.busy, 1);
        @(negedge clk); res("scan3", 20, 1, 1); chk("scan3_busy", bus.busy, 1);
        @(negedge clk); res("scan_end", 20, 0, 0); chk("scan_end_busy", bus.busy, 0);
        issue(0, 1, 0, '0); @(negedge clk); res("hold_kept", 15, 1, 1);

        issue(3, 0, 0, '0);
        @(negedge clk); res("sum_w1", 15, 0, 0); chk("sum_ready", bus.cmd_ready, 0);
        @(negedge clk); res("sum_w2", 15, 0, 0);
        @(negedge clk); res("sum_w3", 15, 0, 0);
        @(negedge clk); res("sum", 33, 1, 1); chk("sum_ready_after", bus.cmd_ready, 1);

        issue(2, 0, 1, 16'h1111);
        @(negedge clk); res("byp1", 2, 1, 0);
        @(negedge clk); res("byp2", 2, 1, 0);
        @(negedge clk); res("byp3", 2, 1, 1);
        @(negedge clk); chk("byp_busy", bus.busy, 0);

        @(posedge clk); #1; bus.load = 1; bus.d = 16'hF3A5;
        @(posedge clk); #1; bus.load = 0;
        bus.cmd_valid = 1; bus.cmd_op = 2'd0; bus.cmd_sel = 2'd1;
        @(posedge clk); #1; bus.cmd_sel = 2'd2;
        @(negedge clk); res("b2b1", 15, 1, 1);
        @(posedge clk); #1; bus.cmd_sel = 2'd3;
        @(negedge clk); res("b2b2", 8, 1, 1);
        @(posedge clk); #1; bus.cmd_valid = 0;
        @(negedge clk); res("b2b3", 20, 1, 1);

        issue(3, 0, 0, '0);
        @(negedge clk); #1; rst = 1'b0; #1;
        res("rst_mid", 0, 0, 0);
        chk("rst_mid_busy", bus.busy, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("rst_hold_valid", bus.validout, 0);
        rst = 1'b1;
        issue(0, 1, 0, '0); @(negedge clk); res("post_rst", 0, 1, 1);

        // Randomized phase: model starts from the cleared hold register
        @(posedge clk); #1;
        hold_out = 0; mhold = '0; bs = 0; be = 0;
        en = 1'b1;
        repeat (3000) begin
            e = cyc;
            if (!p_valid && $urandom_range(2) == 0) begin
                p_valid = 1; p_op = $urandom_range(3); p_sel = $urandom_range(LANES - 1);
            end
            ld = ($urandom_range(3) == 0);
            dv = DW'($urandom);
            bus.cmd_valid = p_valid; bus.cmd_op = 2'(p_op); bus.cmd_sel = 2'(p_sel);
            bus.load = ld; bus.d = dv;
            idle = !(e >= bs && e < be);
            if (idle && ld) mhold = dv;
            if (idle && p_valid) begin
                n = e + 1;
                if (p_op < 2) begin
                    exp_out[n] = ref_result(p_op, p_sel, mhold, 0); exp_last[n] = 1;
                end else if (p_op == 2) begin
                    for (int k = 1; k < LANES; k++) begin
                        exp_out[n + k - 1] = ref_result(2, 0, mhold, k);
                        exp_last[n + k - 1] = (k == LANES - 1);
                    end
                    bs = n; be = n + LANES - 1;
                end else begin
                    exp_out[n + LANES - 1] = ref_result(3, 0, mhold, 0);
                    exp_last[n + LANES - 1] = 1;
                    bs = n; be = n + LANES - 1;
                end
                p_valid = 0;
            end
            @(posedge clk); #1;
        end
        bus.cmd_valid = 0; bus.load = 0;
        repeat (LANES + 2) @(posedge clk);
        #1;
        en = 1'b0;
        chk("rnd_drained", exp_out.num(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
